// File: rtl/pid_scorer_pkg.sv
// Shared types and constants for the 2-bit adder fitness scorer.
// Holds the FSM state encoding, the bit-parallel stimulus vectors, the
// expected adder outputs, and a helper giving the maximum score for a mask.
package pid_scorer_pkg;

    localparam int unsigned NUM_CASES = 16;
    localparam int unsigned SCORE_W   = 7;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned VEC_W     = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_COUNT  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Case i sits on bit i: a = {i[3],i[2]}, b = {i[1],i[0]}
    localparam logic [VEC_W-1:0] STIM_A1 = 16'hFF00;
    localparam logic [VEC_W-1:0] STIM_A0 = 16'hF0F0;
    localparam logic [VEC_W-1:0] STIM_B1 = 16'hCCCC;
    localparam logic [VEC_W-1:0] STIM_B0 = 16'hAAAA;

    // Sum bits of a+b for every case; e1 is bit 1 of the 3-bit sum
    localparam logic [VEC_W-1:0] EXP_E0 = 16'h5A5A;
    localparam logic [VEC_W-1:0] EXP_E1 = 16'h936C;
    localparam logic [VEC_W-1:0] EXP_E2 = 16'hEC80;
    localparam logic [VEC_W-1:0] EXP_E3 = 16'h0000;

    localparam logic [3:0][VEC_W-1:0] EXP_VEC = {EXP_E3, EXP_E2, EXP_E1, EXP_E0};

    // 16 hits per enabled output
    function automatic logic [SCORE_W-1:0] max_score(input logic [3:0] mask);
        logic [SCORE_W-1:0] n;
        n = '0;
        for (int k = 0; k < 4; k++) begin
            n = n + SCORE_W'(mask[k]);
        end
        return n << 4;
    endfunction

endpackage

// File: rtl/pid_fitness_scorer_hit_count4.sv
// Masked match counter for one test case across the four candidate outputs.
// Ports: cap (sampled bits), expv (expected bits), mask (scoring enables),
//        hits_c (number of enabled bits where cap equals expv, 0..4).
module pid_hit_count4
    import pid_scorer_pkg::*;
(
    input  logic [3:0] cap,
    input  logic [3:0] expv,
    input  logic [3:0] mask,
    output logic [2:0] hits_c
);

    logic [3:0] match;

    always_comb begin
        match  = ~(cap ^ expv) & mask;
        hits_c = 3'(match[0]) + 3'(match[1]) + 3'(match[2]) + 3'(match[3]);
    end

endmodule

// File: rtl/pid_fitness_scorer.sv
// Fitness scorer for evolved 2-bit adder candidates: drives the stimulus
// vectors, samples the candidate's four outputs and counts matching bits
// against the adder truth table.
// Ports: clk/rst (sync, active high); start/busy/done handshake to the host;
//        score (hit count 0..64) and perfect (score at maximum), held after
//        done; a1,a0,b1,b0 stimulus to the candidate; y3..y0 candidate outputs.
// Optional: define PID_SCORER_ERRMAP_EN to add err_map[15:0], one bit per
//        test case flagging any mismatch on a scored output.
module pid_fitness_scorer
    import pid_scorer_pkg::*;
#(
    parameter int unsigned SETTLE   = 2,
    parameter logic [3:0]  OUT_MASK = 4'b0111
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [SCORE_W-1:0] score,
    output logic               perfect,
    output logic [VEC_W-1:0]   a1,
    output logic [VEC_W-1:0]   a0,
    output logic [VEC_W-1:0]   b1,
    output logic [VEC_W-1:0]   b0,
    input  logic [VEC_W-1:0]   y3,
    input  logic [VEC_W-1:0]   y2,
    input  logic [VEC_W-1:0]   y1,
    input  logic [VEC_W-1:0]   y0
`ifdef PID_SCORER_ERRMAP_EN
    ,
    output logic [VEC_W-1:0]   err_map
`endif
);

    state_t                 state;
    state_t                 state_next;
    logic [CNT_W-1:0]       cnt;
    logic [3:0][VEC_W-1:0]  cap;
    logic [3:0]             cap_bits;
    logic [3:0]             exp_bits;
    logic [2:0]             hits_c;
    logic                   busy_d;
    logic                   done_d;
    logic                   stim_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state logic; cnt counts settle cycles in DRIVE and cases in COUNT
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_DRIVE;
            ST_DRIVE:  if (cnt == CNT_W'(SETTLE - 1)) state_next = ST_SAMPLE;
            ST_SAMPLE: state_next = ST_COUNT;
            ST_COUNT:  if (cnt == CNT_W'(NUM_CASES - 1)) state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Output decode: values the output registers take at the next edge
    always_comb begin
        busy_d = (state_next != ST_IDLE);
        done_d = (state == ST_DONE);
        stim_d = (state_next == ST_DRIVE) || (state_next == ST_SAMPLE);
    end

    // Bit column under evaluation this COUNT cycle
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            cap_bits[k] = cap[k][cnt];
            exp_bits[k] = EXP_VEC[k][cnt];
        end
    end

    pid_hit_count4 u_hits (
        .cap    (cap_bits),
        .expv   (exp_bits),
        .mask   (OUT_MASK),
        .hits_c (hits_c)
    );

    // Registered outputs, capture and score accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            score   <= '0;
            perfect <= 1'b0;
            a1      <= '0;
            a0      <= '0;
            b1      <= '0;
            b0      <= '0;
            cnt     <= '0;
            cap     <= '0;
`ifdef PID_SCORER_ERRMAP_EN
            err_map <= '0;
`endif
        end else begin
            busy <= busy_d;
            done <= done_d;
            a1   <= stim_d ? STIM_A1 : '0;
            a0   <= stim_d ? STIM_A0 : '0;
            b1   <= stim_d ? STIM_B1 : '0;
            b0   <= stim_d ? STIM_B0 : '0;
            cnt  <= ((state_next != state) || (state == ST_IDLE)) ? '0 : cnt + CNT_W'(1);

            if ((state == ST_IDLE) && start) begin
                score   <= '0;
                perfect <= 1'b0;
`ifdef PID_SCORER_ERRMAP_EN
                err_map <= '0;
`endif
            end

            if (state == ST_SAMPLE) cap <= {y3, y2, y1, y0};

            if (state == ST_COUNT) begin
                score <= score + SCORE_W'(hits_c);
`ifdef PID_SCORER_ERRMAP_EN
                err_map[cnt] <= |((cap_bits ^ exp_bits) & OUT_MASK);
`endif
            end

            if (state == ST_DONE) perfect <= (score == max_score(OUT_MASK));
        end
    end

endmodule

// File: tb/tb_pid_fitness_scorer.sv
// Self-checking bench for pid_fitness_scorer: four instances with different
// masks and settle times share start/rst, each driving its own behavioural
// candidate. Table vectors cover the known-answer cases; random candidates
// are scored by a truth-table reference model.
module tb_pid_fitness_scorer;

    // Instance configuration, nibble g belongs to instance g
    localparam logic [15:0] MASKS = {4'b0100, 4'b0001, 4'b1111, 4'b0111};
    localparam logic [15:0] SETS  = {4'd1, 4'd5, 4'd2, 4'd2};

    logic clk = 1'b0;
    logic rst;
    logic start;
    always #5 clk = ~clk;

    logic [15:0] st_a1 [4];
    logic [15:0] st_a0 [4];
    logic [15:0] st_b1 [4];
    logic [15:0] st_b0 [4];
    logic [15:0] yv [4][4];
    logic        busy_v [4];
    logic        done_v [4];
    logic        perf_v [4];
    logic [6:0]  score_v [4];
`ifdef PID_SCORER_ERRMAP_EN
    logic [15:0] em_v [4];
`endif

    // Candidate behaviour: true adder or fixed pattern, then bit flips
    logic              use_adder;
    logic [3:0][15:0]  base;
    logic [3:0][15:0]  flip;

    int errors = 0;
    int checks = 0;
    int lat_r [4];
    int nd_r [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        pid_fitness_scorer #(
            .SETTLE   (32'(SETS[g*4 +: 4])),
            .OUT_MASK (MASKS[g*4 +: 4])
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .start   (start),
            .busy    (busy_v[g]),
            .done    (done_v[g]),
            .score   (score_v[g]),
            .perfect (perf_v[g]),
            .a1      (st_a1[g]),
            .a0      (st_a0[g]),
            .b1      (st_b1[g]),
            .b0      (st_b0[g]),
            .y3      (yv[g][3]),
            .y2      (yv[g][2]),
            .y1      (yv[g][1]),
            .y0      (yv[g][0])
`ifdef PID_SCORER_ERRMAP_EN
            ,
            .err_map (em_v[g])
`endif
        );
    end

    // Combinational candidates, one per instance, fed by its own stimulus
    logic [2:0] cs;
    always_comb begin
        cs = '0;
        for (int u = 0; u < 4; u++)
            for (int k = 0; k < 4; k++)
                yv[u][k] = '0;
        for (int u = 0; u < 4; u++) begin
            for (int i = 0; i < 16; i++) begin
                cs = 3'({st_a1[u][i], st_a0[u][i]}) + 3'({st_b1[u][i], st_b0[u][i]});
                for (int k = 0; k < 4; k++)
                    yv[u][k][i] = (use_adder ? 1'(cs >> k) : base[k][i]) ^ flip[k][i];
            end
        end
    end

    // Reference: score the candidate against a+b for every case
    function automatic int model_score(input logic [3:0] mask, output logic [15:0] em);
        int sc;
        sc = 0;
        em = '0;
        for (int i = 0; i < 16; i++) begin
            int s;
            s = (i / 4) + (i % 4);
            for (int k = 0; k < 4; k++) begin
                logic e;
                logic y;
                e = 1'((s >> k) & 1);
                y = (use_adder ? e : base[k][i]) ^ flip[k][i];
                if (mask[k]) begin
                    if (y == e) sc++;
                    else        em[i] = 1'b1;
                end
            end
        end
        return sc;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // One evaluation; optional extra start pulse or reset at loop cycle c
    task automatic run_eval(input int extra_at, input int rst_at);
        for (int u = 0; u < 4; u++) begin
            lat_r[u] = -1;
            nd_r[u]  = 0;
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int u = 0; u < 4; u++) check("busy_on_accept", u, 32'(busy_v[u]), 1);
        check("stim_a1", 0, 32'(st_a1[0]), 32'h0000FF00);
        check("stim_b0", 0, 32'(st_b0[0]), 32'h0000AAAA);
        for (int c = 1; c <= 40; c++) begin
            if (c == extra_at) start = 1'b1;
            if (c == rst_at)   rst = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            if (c == rst_at) begin
                rst = 1'b0;
                break;
            end
            for (int u = 0; u < 4; u++) begin
                if (done_v[u]) begin
                    nd_r[u]++;
                    if (lat_r[u] < 0) lat_r[u] = c;
                end
            end
        end
    endtask

    typedef struct {
        logic             use_adder;
        logic [3:0][15:0] base;
        logic [3:0][15:0] flip;
        int               extra_at;
        int               sc [4];
        logic             pf [4];
        logic [15:0]      em [4];
    } vec_t;

    vec_t vecs [5];

    task automatic set_exp(input int n, input int s0, input int s1, input int s2, input int s3,
                           input logic [3:0] pf, input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3);
        vecs[n].sc[0] = s0; vecs[n].sc[1] = s1; vecs[n].sc[2] = s2; vecs[n].sc[3] = s3;
        for (int u = 0; u < 4; u++) vecs[n].pf[u] = pf[u];
        vecs[n].em[0] = e0; vecs[n].em[1] = e1; vecs[n].em[2] = e2; vecs[n].em[3] = e3;
    endtask

    task automatic check_reset_state(input string tag);
        for (int u = 0; u < 4; u++) begin
            check({tag, "_busy"}, u, 32'(busy_v[u]), 0);
            check({tag, "_done"}, u, 32'(done_v[u]), 0);
            check({tag, "_score"}, u, 32'(score_v[u]), 0);
            check({tag, "_perfect"}, u, 32'(perf_v[u]), 0);
            check({tag, "_stim"}, u, 32'(st_a1[u] | st_a0[u] | st_b1[u] | st_b0[u]), 0);
`ifdef PID_SCORER_ERRMAP_EN
            check({tag, "_errmap"}, u, 32'(em_v[u]), 0);
`endif
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          exp_sc;
        logic [15:0] exp_em;

        rst = 1'b1;
        start = 1'b0;
        use_adder = 1'b0;
        base = '0;
        flip = '0;

        // Known-answer vectors: ideal, zeros, ones, y0 bit 5 flipped, ideal + extra start
        for (int n = 0; n < 5; n++) begin
            vecs[n].use_adder = 1'b1;
            vecs[n].base = '0;
            vecs[n].flip = '0;
            vecs[n].extra_at = 0;
        end
        set_exp(0, 48, 64, 16, 16, 4'b1111, 16'h0, 16'h0, 16'h0, 16'h0);
        vecs[1].use_adder = 1'b0;
        set_exp(1, 26, 42, 8, 10, 4'b0000, 16'hFFFE, 16'hFFFE, 16'h5A5A, 16'hEC80);
        vecs[2].use_adder = 1'b0;
        vecs[2].base = {4{16'hFFFF}};
        set_exp(2, 22, 22, 8, 6, 4'b0000, 16'hFFFF, 16'hFFFF, 16'hA5A5, 16'h137F);
        vecs[3].flip[0] = 16'h0020;
        set_exp(3, 47, 63, 15, 16, 4'b1000, 16'h0020, 16'h0020, 16'h0020, 16'h0000);
        vecs[4].extra_at = 10;
        set_exp(4, 48, 64, 16, 16, 4'b1111, 16'h0, 16'h0, 16'h0, 16'h0);

        repeat (3) @(posedge clk);
        #1;
        check_reset_state("in_reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset_state("after_reset");

        for (int n = 0; n < 5; n++) begin
            use_adder = vecs[n].use_adder;
            base = vecs[n].base;
            flip = vecs[n].flip;
            run_eval(vecs[n].extra_at, 0);
            for (int u = 0; u < 4; u++) begin
                check("latency", n * 4 + u, 32'(lat_r[u]), 32'(SETS[u*4 +: 4]) + 18);
                check("done_count", n * 4 + u, 32'(nd_r[u]), 1);
                check("score", n * 4 + u, 32'(score_v[u]), 32'(vecs[n].sc[u]));
                check("perfect", n * 4 + u, 32'(perf_v[u]), 32'(vecs[n].pf[u]));
                check("busy_idle", n * 4 + u, 32'(busy_v[u]), 0);
`ifdef PID_SCORER_ERRMAP_EN
                check("err_map", n * 4 + u, 32'(em_v[u]), 32'(vecs[n].em[u]));
`endif
            end
        end

        // Result holds while idle, then reset in IDLE clears it
        use_adder = 1'b1; base = '0; flip = '0;
        run_eval(0, 0);
        repeat (4) @(posedge clk);
        #1;
        check("hold_score", 0, 32'(score_v[0]), 48);
        check("hold_perfect", 0, 32'(perf_v[0]), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_state("idle_reset");

        // Reset while instance 2 is in DRIVE (stimulus active)
        run_eval(0, 4);
        check_reset_state("drive_reset");

        // Reset while all instances are in COUNT with partial scores
        run_eval(0, 12);
        check_reset_state("count_reset");

        // Fresh evaluation after the mid-run reset
        run_eval(0, 0);
        for (int u = 0; u < 4; u++) begin
            check("post_rst_latency", u, 32'(lat_r[u]), 32'(SETS[u*4 +: 4]) + 18);
            check("post_rst_score", u, 32'(score_v[u]), 32'(vecs[0].sc[u]));
            check("post_rst_perfect", u, 32'(perf_v[u]), 1);
        end

        // Random candidates against the truth-table model
        for (int r = 0; r < 10; r++) begin
            use_adder = 1'($urandom_range(0, 1));
            for (int k = 0; k < 4; k++) begin
                base[k] = 16'($urandom);
                flip[k] = 16'($urandom & $urandom & $urandom);
            end
            run_eval(0, 0);
            for (int u = 0; u < 4; u++) begin
                exp_sc = model_score(MASKS[u*4 +: 4], exp_em);
                check("rand_score", r * 4 + u, 32'(score_v[u]), 32'(exp_sc));
                check("rand_perfect", r * 4 + u, 32'(perf_v[u]),
                      32'(exp_sc == 16 * $countones(MASKS[u*4 +: 4])));
                check("rand_done_count", r * 4 + u, 32'(nd_r[u]), 1);
`ifdef PID_SCORER_ERRMAP_EN
                check("rand_err_map", r * 4 + u, 32'(em_v[u]), 32'(exp_em));
`endif
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
